pp_column_feeder: RTL and testbench

- Upstream stage of the mul32 column compressor path. Accepts one operand pair (a, b) per request.
- Over WIDTH consecutive cycles it drives one partial-product bit per column into the per-column shift register in front of the compressor.
- When the burst ends, each column register holds exactly its partial-product bits: column c holds min(c+1, 2*WIDTH-1-c) bits.
- done strobes in the single cycle in which the compressor output is the valid product.

---
 rtl/pp_column_feeder.sv | 81 ++++++++
 tb/tb_pp_column_feeder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pp_column_feeder.sv
// rtl/pp_column_feeder.sv - streams one partial-product bit per column into the mul column compressor shift registers
module pp_column_feeder #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-2:0] pp,
    output logic               busy,
    output logic               done
);
    localparam int SW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int NCOL = 2 * WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] a_q, b_q;
    logic             accept;
    logic             last_step;
    logic             run;

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_step = (step == SW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            step <= '0;
            a_q  <= a;
            b_q  <= b;
        end else if (state == RUN) begin
            step <= step + SW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_step) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        run  = (state == RUN);
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Column c emits its w_c real bits on the last w_c steps so earlier zeros
    // fall out of its w_c-deep register by the done cycle.
    for (genvar c = 0; c < NCOL; c++) begin : g_col
        localparam int I_LO = (c > WIDTH - 1) ? c - (WIDTH - 1) : 0;
        localparam int W_C  = (c + 1 < NCOL - c) ? c + 1 : NCOL - c;
        localparam int OFF  = WIDTH - W_C;

        logic [SW-1:0] ia;
        logic [SW-1:0] jb;

        assign ia = SW'(I_LO) + step - SW'(OFF);
        assign jb = SW'(c) - ia;
        assign pp[c] = run && (step >= SW'(OFF)) && a_q[ia] && b_q[jb];
    end
endmodule

// File: tb/tb_pp_column_feeder.sv
// tb/tb_pp_column_feeder.sv - scoreboard bench for pp_column_feeder with a column shift-register compressor model
module tb_pp_column_feeder;
    localparam int W    = 32;
    localparam int NCOL = 2 * W - 1;

    typedef struct {
        logic [63:0] prod;
        int unsigned at_edge;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic [NCOL-1:0] pp;
    logic            busy;
    logic            done;

    int          n_chk = 0;
    int          n_err = 0;
    int unsigned ecnt = 0;
    int          cnt = 0;
    logic        accepted;
    exp_t        sb[$];
    logic [W-1:0] col [NCOL];

    pp_column_feeder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .pp(pp), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic int w_of(input int c);
        return (c + 1 < NCOL - c) ? c + 1 : NCOL - c;
    endfunction

    // Downstream compressor: every column shifts each edge; evaluate in the done cycle.
    always @(negedge clk) begin
        logic [63:0] sum;
        exp_t e;
        if (done === 1'b1) begin
            sum = '0;
            for (int c = 0; c < NCOL; c++) begin
                logic [63:0] bits;
                bits = 64'(col[c]) & ((64'd1 << w_of(c)) - 64'd1);
                sum = sum + (64'($countones(bits)) << c);
            end
            n_chk++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done at edge %0d product %h", ecnt, sum);
            end else begin
                e = sb.pop_front();
                if (sum !== e.prod || ecnt != e.at_edge) begin
                    n_err++;
                    $display("FAIL product got %h at edge %0d, want %h at edge %0d",
                             sum, ecnt, e.prod, e.at_edge);
                end
            end
        end
        for (int c = 0; c < NCOL; c++) col[c] = {col[c][W-2:0], pp[c]};
    end

    task automatic check(input string name, input logic [NCOL-1:0] got, input logic [NCOL-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Acceptance model: a start is honoured only once the previous burst's WIDTH RUN cycles are over.
    task automatic drive(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv);
        start = st;
        a = av;
        b = bv;
        @(posedge clk);
        accepted = 1'b0;
        if (rst) cnt = 0;
        else if (cnt == 0 && st) begin
            accepted = 1'b1;
            cnt = W;
        end else if (cnt > 0) cnt--;
        #1;
        if (accepted) sb.push_back('{64'(av) * 64'(bv), ecnt + W});
    endtask

    function automatic logic [NCOL-1:0] exp_pp(input int kind, input int s);
        logic [NCOL-1:0] v;
        v = '0;
        case (kind)
            0: v[0] = (s == W - 1);
            1: v[NCOL-1] = (s == W - 1);
            default: for (int c = 0; c < NCOL; c++) v[c] = (s >= W - w_of(c));
        endcase
        return v;
    endfunction

    task automatic run_directed(input logic [W-1:0] av, input logic [W-1:0] bv, input int kind);
        drive(1'b1, av, bv);
        check("accept", {62'd0, accepted}, 63'd1);
        for (int s = 0; s < W; s++) begin
            check("busy_run", {62'd0, busy}, 63'd1);
            check("pp_step", pp, exp_pp(kind, s));
            drive(1'b0, $urandom, $urandom);
        end
        check("done_cycle", {61'd0, busy, done}, 63'd1);
        check("pp_done", pp, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) drive(1'b0, $urandom, $urandom);
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        int unsigned e_mark;
        for (int c = 0; c < NCOL; c++) col[c] = '0;
        #1;
        check("reset_outputs", {pp[NCOL-1:2] | {NCOL-2{busy | done}}, busy, done}, '0);
        repeat (2) drive(1'b0, '0, '0);
        rst = 1'b0;
        drive(1'b0, '0, '0);

        // Asynchronous reset in the middle of a burst
        drive(1'b1, '1, '1);
        repeat (10) drive(1'b0, $urandom, $urandom);
        check("pre_reset_busy", {62'd0, busy}, 63'd1);
        check("pre_reset_pp31", {62'd0, pp[31]}, 63'd1);
        e_mark = ecnt;
        #2 rst = 1'b1;
        #1;
        check("async_pp", pp, '0);
        check("async_busy_done", {61'd0, busy, done}, '0);
        check("async_no_edge", 63'(ecnt), 63'(e_mark));
        sb.delete();
        cnt = 0;
        repeat (2) drive(1'b0, $urandom, $urandom);
        rst = 1'b0;
        repeat (40) drive(1'b0, $urandom, $urandom);

        run_directed('1, '1, 2);
        run_directed(32'h0000_0001, 32'h0000_0001, 0);
        run_directed(32'h8000_0000, 32'h8000_0000, 1);
        drain();

        // Back-to-back with start held high
        drive(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 32'd3, 32'd5);
            if (accepted) break;
        end
        drain();

        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] av, bv;
            av = $urandom;
            bv = $urandom;
            if (n % 7 == 0) av = '1;
            if (n % 11 == 0) bv = '0;
            repeat ($urandom_range(0, 2)) drive(1'b0, $urandom, $urandom);
            for (int i = 0; i < 40; i++) begin
                drive(1'b1, av, bv);
                if (accepted) break;
            end
            repeat ($urandom_range(0, 5)) drive(1'($urandom), $urandom, $urandom);
        end
        drain();
        repeat (40) drive(1'b0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
